wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone B4 pipelined arbiter. It shares a single slave port between the Ibex instruction-fetch master (m0) and the data master (m1) produced by the core-to-Wishbone bridges. It grants the bus per Wishbone cycle (`cyc`) using round-robin on contention, and tracks outstanding transfers. A watchdog aborts a granted cycle whose slave stops responding, so the core cannot hang on a dead address.

---
 rtl/wb_arbiter_2m.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 pipelined arbiter sharing one slave port between the
// instruction-fetch (m0) and data (m1) masters, with an outstanding cap and a response watchdog.
module wb_arbiter_2m #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_dat_w,
  output logic            m0_stall,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_dat_r,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_dat_w,
  output logic            m1_stall,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_dat_r,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_w,
  input  logic            s_stall,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_r,
  output logic [1:0]      grant,
  output logic            timeout
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, ABORT} state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [8:0] WD_LIM  = 9'(TIMEOUT);

  state_t      state;
  logic        last_grant;   // 0 = m0, 1 = m1; also names the owner while busy/aborting
  logic [3:0]  outstanding;
  logic [7:0]  wd_cnt;

  logic        busy0, busy1, aborting, cap, owner_cyc, accept, resp, dec;
  logic [8:0]  wd_inc;

  assign busy0     = (state == BUSY0);
  assign busy1     = (state == BUSY1);
  assign aborting  = (state == ABORT);
  assign cap       = (outstanding == MAX_OUT);
  assign owner_cyc = last_grant ? m1_cyc : m0_cyc;
  assign accept    = s_stb & ~s_stall;
  assign resp      = s_ack | s_err;
  assign dec       = resp & (outstanding != 4'd0);
  assign wd_inc    = {1'b0, wd_cnt} + 9'd1;

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_w = '0;
    if (busy0) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb & ~cap;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_sel   = m0_sel;
      s_dat_w = m0_dat_w;
    end else if (busy1) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb & ~cap;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_sel   = m1_sel;
      s_dat_w = m1_dat_w;
    end
  end

  // Responses reach only the current owner; the abort error rides on the timeout pulse.
  assign m0_stall = busy0 ? (s_stall | cap) : 1'b1;
  assign m1_stall = busy1 ? (s_stall | cap) : 1'b1;
  assign m0_ack   = busy0 & s_ack;
  assign m1_ack   = busy1 & s_ack;
  assign m0_err   = (busy0 & s_err) | (aborting & ~last_grant & timeout);
  assign m1_err   = (busy1 & s_err) | (aborting & last_grant & timeout);
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      outstanding <= 4'd0;
      wd_cnt      <= 8'd0;
      grant       <= 2'b00;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          outstanding <= 4'd0;
          wd_cnt      <= 8'd0;
          if (m0_cyc && (!m1_cyc || last_grant)) begin
            state      <= BUSY0;
            last_grant <= 1'b0;
            grant      <= 2'b01;
          end else if (m1_cyc) begin
            state      <= BUSY1;
            last_grant <= 1'b1;
            grant      <= 2'b10;
          end
        end
        BUSY0, BUSY1: begin
          if (!owner_cyc) begin
            state       <= IDLE;
            grant       <= 2'b00;
            outstanding <= 4'd0;
            wd_cnt      <= 8'd0;
          end else begin
            outstanding <= outstanding + {3'b000, accept} - {3'b000, dec};
            if (resp || outstanding == 4'd0) begin
              wd_cnt <= 8'd0;
            end else if (TIMEOUT != 0 && wd_inc == WD_LIM) begin
              state       <= ABORT;
              timeout     <= 1'b1;
              wd_cnt      <= 8'd0;
              outstanding <= 4'd0;
            end else begin
              wd_cnt <= wd_inc[7:0];
            end
          end
        end
        ABORT: begin
          outstanding <= 4'd0;
          wd_cnt      <= 8'd0;
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus a randomized
// two-master run scored end to end against a FIFO slave and per-master expectation queues.
module tb_wb_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m0_stall, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic [3:0]  m0_sel;
  logic        m1_cyc, m1_stb, m1_we, m1_stall, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic [3:0]  m1_sel;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack, s_err;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic        timeout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(32), .DW(32), .MAX_OUTSTANDING(4), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_w(m0_dat_w), .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_r(m0_dat_r),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_w(m1_dat_w), .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_r(m1_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel), .s_dat_w(s_dat_w),
    .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err), .s_dat_r(s_dat_r),
    .grant(grant), .timeout(timeout)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_sel = 0; m0_dat_w = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_sel = 0; m1_dat_w = 0;
    s_stall = 0; s_ack = 0; s_err = 0; s_dat_r = 0;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = $urandom; m0_sel = 4'hF; m0_dat_w = $urandom;
    m1_cyc = 1; m1_stb = 1;
    s_ack = 1; s_err = 1; s_dat_r = $urandom;
    tick(); tick();
    n_checks++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) $display("FAIL reset_s_ctl: got %b want 000", {s_cyc, s_stb, s_we});
    else n_pass++;
    n_checks++;
    if (s_adr !== 0 || s_sel !== 0 || s_dat_w !== 0)
      $display("FAIL reset_s_bus: got adr %h sel %h dat %h want all 0", s_adr, s_sel, s_dat_w);
    else n_pass++;
    n_checks++;
    if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000)
      $display("FAIL reset_resp: got %b want 0000", {m0_ack, m0_err, m1_ack, m1_err});
    else n_pass++;
    n_checks++;
    if ({m0_stall, m1_stall} !== 2'b11) $display("FAIL reset_stall: got %b want 11", {m0_stall, m1_stall});
    else n_pass++;
    n_checks++;
    if (grant !== 2'b00 || timeout !== 1'b0) $display("FAIL reset_grant: got %b/%b want 00/0", grant, timeout);
    else n_pass++;
    rst = 0;
    idle_in();
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] a0, a1, d;
    a0 = $urandom; a1 = $urandom; d = $urandom;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = a0;
    m1_cyc = 1; m1_stb = 1; m1_adr = a1;
    #1;
    n_checks++;
    if (grant !== 2'b00) $display("FAIL tie_latency: got %b want 00", grant); else n_pass++;
    tick(); #1;
    n_checks++;
    if (grant !== 2'b10 || s_adr !== a1 || s_stb !== 1'b1)
      $display("FAIL tie_m1_first: got grant %b adr %h stb %b want 10 %h 1", grant, s_adr, s_stb, a1);
    else n_pass++;
    n_checks++;
    if (m0_stall !== 1'b1 || m1_stall !== 1'b0)
      $display("FAIL tie_stalls: got m0 %b m1 %b want 1 0", m0_stall, m1_stall);
    else n_pass++;
    tick();
    m1_stb = 0; s_ack = 1; s_dat_r = d;
    #1;
    n_checks++;
    if (m1_ack !== 1'b1 || m1_dat_r !== d || m0_ack !== 1'b0 || m0_stall !== 1'b1)
      $display("FAIL tie_resp: got m1_ack %b dat %h m0_ack %b m0_stall %b want 1 %h 0 1",
               m1_ack, m1_dat_r, m0_ack, m0_stall, d);
    else n_pass++;
    tick();
    s_ack = 0; m1_cyc = 0;
    tick(); #1;
    n_checks++;
    if (grant !== 2'b00 || m0_stall !== 1'b1) $display("FAIL tie_release: got %b/%b want 00/1", grant, m0_stall);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (grant !== 2'b01 || s_adr !== a0 || s_stb !== 1'b1)
      $display("FAIL tie_m0_next: got grant %b adr %h stb %b want 01 %h 1", grant, s_adr, s_stb, a0);
    else n_pass++;
    tick();
    m0_stb = 0; s_ack = 1;
    #1;
    n_checks++;
    if (m0_ack !== 1'b1) $display("FAIL tie_m0_ack: got %b want 1", m0_ack); else n_pass++;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_burst();
    logic [31:0] adr [4];
    logic [31:0] dat [4];
    int acks = 0;
    for (int i = 0; i < 4; i++) begin adr[i] = $urandom; dat[i] = $urandom; end
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = adr[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      m1_stb = (i < 4);
      if (i < 4) m1_adr = adr[i];
      s_ack = (i > 0);
      if (i > 0) s_dat_r = dat[i-1];
      #1;
      if (i == 0) begin
        n_checks++;
        if (grant !== 2'b10) $display("FAIL burst_grant: got %b want 10", grant); else n_pass++;
      end
      if (i < 4) begin
        n_checks++;
        if (s_stb !== 1'b1 || s_adr !== adr[i])
          $display("FAIL burst_req%0d: got stb %b adr %h want 1 %h", i, s_stb, s_adr, adr[i]);
        else n_pass++;
      end
      if (i > 0) begin
        if (m1_ack === 1'b1) acks++;
        n_checks++;
        if (m1_ack !== 1'b1 || m1_dat_r !== dat[i-1])
          $display("FAIL burst_ack%0d: got ack %b dat %h want 1 %h", i, m1_ack, m1_dat_r, dat[i-1]);
        else n_pass++;
      end
    end
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); #1;
    n_checks++;
    if (grant !== 2'b00 || m1_stall !== 1'b1) $display("FAIL burst_idle: got %b/%b want 00/1", grant, m1_stall);
    else n_pass++;
    n_checks++;
    if (acks != 4) $display("FAIL burst_ack_count: got %0d want 4", acks); else n_pass++;
    idle_in();
  endtask

  task automatic test_cap();
    int acc = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = $urandom;
    for (int k = 0; k < 6; k++) begin
      tick(); #1;
      if (k >= 4) begin
        n_checks++;
        if (m0_stall !== 1'b1 || s_stb !== 1'b0)
          $display("FAIL cap_hold%0d: got stall %b s_stb %b want 1 0", k, m0_stall, s_stb);
        else n_pass++;
      end
      if (s_stb === 1'b1 && s_stall === 1'b0) begin acc++; m0_adr = $urandom; end
    end
    n_checks++;
    if (acc != 4) $display("FAIL cap_accepts: got %0d want 4", acc); else n_pass++;
    tick();
    s_ack = 1;
    #1;
    n_checks++;
    if (m0_ack !== 1'b1 || m0_stall !== 1'b1)
      $display("FAIL cap_ack: got ack %b stall %b want 1 1", m0_ack, m0_stall);
    else n_pass++;
    tick();
    s_ack = 0;
    #1;
    n_checks++;
    if (m0_stall !== 1'b0 || s_stb !== 1'b1)
      $display("FAIL cap_fifth: got stall %b s_stb %b want 0 1", m0_stall, s_stb);
    else n_pass++;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_watchdog();
    logic [31:0] wd;
    int found = 0;
    int early = 0;
    wd = $urandom;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = $urandom; m1_dat_w = wd;
    tick(); #1;
    n_checks++;
    if (s_stb !== 1'b1 || s_we !== 1'b1 || s_dat_w !== wd || grant !== 2'b10)
      $display("FAIL wd_accept: got stb %b we %b dat %h grant %b want 1 1 %h 10", s_stb, s_we, s_dat_w, grant, wd);
    else n_pass++;
    for (int k = 1; k <= 20; k++) begin
      tick();
      m1_stb = 0;
      #1;
      if (timeout === 1'b1) begin found = k; break; end
      if (m1_err !== 1'b0) early++;
    end
    n_checks++;
    if (found != 11) $display("FAIL wd_delay: got %0d cycles want 11", found); else n_pass++;
    n_checks++;
    if (early != 0) $display("FAIL wd_early_err: got %0d want 0", early); else n_pass++;
    n_checks++;
    if (m1_err !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0 || m1_stall !== 1'b1)
      $display("FAIL wd_abort: got err %b s_cyc %b s_stb %b stall %b want 1 0 0 1", m1_err, s_cyc, s_stb, m1_stall);
    else n_pass++;
    tick();
    s_ack = 1;
    #1;
    n_checks++;
    if (timeout !== 1'b0 || m1_err !== 1'b0 || m1_ack !== 1'b0 || s_cyc !== 1'b0 || m1_stall !== 1'b1)
      $display("FAIL wd_abort2: got to %b err %b ack %b s_cyc %b stall %b want 0 0 0 0 1",
               timeout, m1_err, m1_ack, s_cyc, m1_stall);
    else n_pass++;
    tick();
    m1_cyc = 0; s_ack = 0;
    tick();
    s_ack = 1;
    #1;
    n_checks++;
    if (grant !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0)
      $display("FAIL wd_late_ack: got grant %b acks %b%b want 00 00", grant, m0_ack, m1_ack);
    else n_pass++;
    tick();
    idle_in();
  endtask

  task automatic test_master_abort();
    int stalls = 0;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = $urandom;
    tick();
    tick();
    m0_adr = $urandom;
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick();
    s_ack = 1;
    #1;
    n_checks++;
    if (grant !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0)
      $display("FAIL mabort_idle: got grant %b acks %b%b want 00 00", grant, m0_ack, m1_ack);
    else n_pass++;
    tick();
    s_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      if (m0_stall !== 1'b0) stalls++;
      m0_adr = $urandom;
    end
    n_checks++;
    if (stalls != 0) $display("FAIL mabort_cnt_clear: got %0d stalls want 0", stalls); else n_pass++;
    tick();
    idle_in();
    tick();
  endtask

  task automatic test_random();
    int          act [2];
    int          left [2];
    int          gap [2];
    int          done [2];
    logic [31:0] cur [2];
    logic        curwe [2];
    logic [32:0] expq0 [$];
    logic [32:0] expq1 [$];
    logic [31:0] sq [$];
    logic [32:0] e;
    logic        sa, se, racc, rack, rerr;
    int          viol = 0, m_acc = 0, s_acc = 0, iter = 0, hits, qs;
    logic        fin = 0;
    idle_in();
    for (int m = 0; m < 2; m++) begin
      act[m] = 0; left[m] = 0; gap[m] = m; done[m] = 0;
      cur[m] = $urandom; curwe[m] = 1'($urandom_range(0, 1));
    end
    while (!fin && iter < 4000) begin
      tick();
      iter++;
      for (int m = 0; m < 2; m++) begin
        qs = (m == 0) ? expq0.size() : expq1.size();
        if (act[m] == 0) begin
          if (gap[m] > 0) gap[m]--;
          else if (done[m] < 15) begin act[m] = 1; left[m] = $urandom_range(1, 3); end
        end else if (left[m] == 0 && qs == 0) begin
          act[m] = 0; done[m]++; gap[m] = $urandom_range(0, 3);
        end
      end
      m0_cyc = (act[0] != 0); m0_stb = (act[0] != 0 && left[0] > 0); m0_we = curwe[0];
      m0_adr = cur[0]; m0_dat_w = ~cur[0]; m0_sel = cur[0][3:0];
      m1_cyc = (act[1] != 0); m1_stb = (act[1] != 0 && left[1] > 0); m1_we = curwe[1];
      m1_adr = cur[1]; m1_dat_w = ~cur[1]; m1_sel = cur[1][3:0];
      s_stall = ($urandom_range(0, 3) == 0);
      sa = 0; se = 0; s_dat_r = $urandom;
      if (sq.size() > 0 && $urandom_range(0, 7) != 0) begin
        if ($urandom_range(0, 7) == 0) se = 1; else sa = 1;
        s_dat_r = rd_val(sq[0]);
      end
      s_ack = sa; s_err = se;
      #1;
      hits = 0;
      for (int m = 0; m < 2; m++) begin
        rack = (m == 0) ? m0_ack : m1_ack;
        rerr = (m == 0) ? m0_err : m1_err;
        racc = (m == 0) ? (m0_stb & ~m0_stall) : (m1_stb & ~m1_stall);
        qs   = (m == 0) ? expq0.size() : expq1.size();
        if (rack === 1'b1 || rerr === 1'b1) begin
          hits++;
          if (qs == 0) viol++;
          else begin
            if (m == 0) e = expq0.pop_front(); else e = expq1.pop_front();
            n_checks++;
            if (rack !== sa || rerr !== se || (sa && e[32] && s_dat_r !== e[31:0]))
              $display("FAIL rand_resp_m%0d: got ack %b err %b dat %h want %b %b %h",
                       m, rack, rerr, (m == 0) ? m0_dat_r : m1_dat_r, sa, se, e[31:0]);
            else n_pass++;
          end
        end
        if (racc === 1'b1) begin
          if (m == 0) expq0.push_back({~curwe[m], rd_val(cur[m])});
          else        expq1.push_back({~curwe[m], rd_val(cur[m])});
          left[m]--; m_acc++;
          cur[m] = $urandom; curwe[m] = 1'($urandom_range(0, 1));
        end
      end
      if ((sa || se) && hits != 1) viol++;
      if (!(sa || se) && hits != 0) viol++;
      if (grant === 2'b11) viol++;
      if (s_stb === 1'b1 && s_stall === 1'b0) begin
        s_acc++;
        sq.push_back(s_adr);
        if (s_we === 1'b1) begin
          n_checks++;
          if (s_dat_w !== ~s_adr) $display("FAIL rand_wdata: got %h want %h", s_dat_w, ~s_adr);
          else n_pass++;
        end
      end
      if (sa || se) void'(sq.pop_front());
      fin = (done[0] == 15 && done[1] == 15 && act[0] == 0 && act[1] == 0 && sq.size() == 0);
    end
    n_checks++;
    if (!fin) $display("FAIL rand_complete: got done %0d/%0d after %0d cycles want 15/15", done[0], done[1], iter);
    else n_pass++;
    n_checks++;
    if (viol != 0) $display("FAIL rand_routing: got %0d violations want 0", viol); else n_pass++;
    n_checks++;
    if (m_acc != s_acc || m_acc == 0) $display("FAIL rand_accepts: got master %0d slave %0d want equal, nonzero", m_acc, s_acc);
    else n_pass++;
    idle_in();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int stalls = 0;
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = $urandom;
    tick(); tick(); tick();
    tick();
    m1_stb = 0; m0_cyc = 1; m0_stb = 1; rst = 1;
    tick();
    rst = 0; m1_stb = 1;
    #1;
    n_checks++;
    if ({s_cyc, s_stb, s_we} !== 3'b000 || s_adr !== 0 || grant !== 2'b00 || timeout !== 1'b0)
      $display("FAIL rstmid_outputs: got ctl %b adr %h grant %b to %b want 000 0 00 0",
               {s_cyc, s_stb, s_we}, s_adr, grant, timeout);
    else n_pass++;
    n_checks++;
    if ({m0_stall, m1_stall} !== 2'b11) $display("FAIL rstmid_stall: got %b want 11", {m0_stall, m1_stall});
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (grant !== 2'b10) $display("FAIL rstmid_tie: got %b want 10", grant); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (m1_stall !== 1'b0) stalls++;
      tick(); #1;
    end
    n_checks++;
    if (stalls != 0) $display("FAIL rstmid_cnt_clear: got %0d stalls want 0", stalls); else n_pass++;
    idle_in();
    tick(); tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst = 1;
    test_reset();
    test_contention();
    test_burst();
    test_cap();
    test_watchdog();
    test_master_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
